// File: rtl/ps2_keyboard_rx.sv
// rtl/ps2_keyboard_rx.sv - PS/2 keyboard receiver: sync, clock filter, frame FSM, E0/F0 decode
module ps2_keyboard_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 27000
) (
   input  logic       clock27,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_data_out,
   output logic       key_pressed,
   output logic       key_extended,
   output logic       key_valid,
   output logic       frame_err
);
   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
   logic                   clk_s, dat_s;
   logic                   filt_clk, fall;
   logic [FW-1:0]          filt_cnt;
   logic [TW-1:0]          tmo_cnt;
   state_t                 state;
   logic [2:0]             bit_cnt;
   logic [7:0]             shreg;
   logic                   par_bit, dec_pend, ext_flag, brk_flag;

   assign clk_s = clk_sync[SYNC_STAGES-1];
   assign dat_s = dat_sync[SYNC_STAGES-1];

   always_ff @(posedge clock27 or posedge reset) begin
      if (reset) begin
         clk_sync <= '1;
         dat_sync <= '1;
      end else begin
         clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
         dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_data};
      end
   end

   // Filtered clock flips on the FILTER_LEN-th consecutive differing sample; fall strobes the cycle after.
   always_ff @(posedge clock27 or posedge reset) begin
      if (reset) begin
         filt_clk <= 1'b1;
         filt_cnt <= '0;
         fall     <= 1'b0;
      end else begin
         fall <= 1'b0;
         if (clk_s != filt_clk) begin
            if (filt_cnt == FW'(FILTER_LEN - 1)) begin
               filt_clk <= clk_s;
               filt_cnt <= '0;
               fall     <= filt_clk;
            end else begin
               filt_cnt <= filt_cnt + 1'b1;
            end
         end else begin
            filt_cnt <= '0;
         end
      end
   end

   always_ff @(posedge clock27 or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         bit_cnt      <= '0;
         shreg        <= '0;
         par_bit      <= 1'b0;
         tmo_cnt      <= '0;
         dec_pend     <= 1'b0;
         ext_flag     <= 1'b0;
         brk_flag     <= 1'b0;
         key_data_out <= 8'h00;
         key_pressed  <= 1'b0;
         key_extended <= 1'b0;
         key_valid    <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;
         dec_pend  <= 1'b0;

         if (dec_pend) begin
            if (shreg == 8'hE0) begin
               ext_flag <= 1'b1;
            end else if (shreg == 8'hF0) begin
               brk_flag <= 1'b1;
            end else begin
               if (!brk_flag) begin
                  key_data_out <= shreg;
                  key_extended <= ext_flag;
                  key_pressed  <= 1'b1;
                  key_valid    <= 1'b1;
               end else if (shreg == key_data_out && ext_flag == key_extended) begin
                  key_pressed <= 1'b0;
               end
               ext_flag <= 1'b0;
               brk_flag <= 1'b0;
            end
         end

         if (fall) begin
            tmo_cnt <= '0;
            case (state)
               IDLE: begin
                  if (!dat_s) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               DATA: begin
                  shreg[bit_cnt] <= dat_s;
                  if (bit_cnt == 3'd7) state <= PARITY;
                  else                 bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: begin
                  par_bit <= dat_s;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (dat_s && ^{shreg, par_bit}) begin
                     dec_pend <= 1'b1;
                  end else begin
                     frame_err <= 1'b1;
                     ext_flag  <= 1'b0;
                     brk_flag  <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end else if (state != IDLE) begin
            // Silent device mid-frame: abandon the partial byte without flagging an error.
            if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state   <= IDLE;
               tmo_cnt <= '0;
            end else begin
               tmo_cnt <= tmo_cnt + 1'b1;
            end
         end else begin
            tmo_cnt <= '0;
         end
      end
   end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// tb/tb_ps2_keyboard_rx.sv - directed bench for ps2_keyboard_rx
module tb_ps2_keyboard_rx;
   localparam int H = 20;

   logic       clock27 = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] key_data_out;
   logic       key_pressed, key_extended, key_valid, frame_err;

   int total = 0;
   int bad = 0;
   int vcount = 0;
   int ecount = 0;
   int pulse_bad = 0;
   logic prev_valid = 1'b0;
   logic prev_err = 1'b0;

   ps2_keyboard_rx dut (
      .clock27(clock27), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
      .key_data_out(key_data_out), .key_pressed(key_pressed), .key_extended(key_extended),
      .key_valid(key_valid), .frame_err(frame_err)
   );

   always #5 clock27 = ~clock27;

   always @(posedge clock27) begin
      if (key_valid) vcount <= vcount + 1;
      if (frame_err) ecount <= ecount + 1;
      if ((key_valid && prev_valid) || (frame_err && prev_err) || (key_valid && frame_err))
         pulse_bad <= pulse_bad + 1;
      prev_valid <= key_valid;
      prev_err   <= frame_err;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock27);
   endtask

   task automatic send_bit(input logic b, input logic glitch);
      ps2_data = b;
      if (glitch) begin
         wait_cyc(5);
         ps2_clk = 1'b0;
         wait_cyc(3);
         ps2_clk = 1'b1;
         wait_cyc(H - 8);
      end else begin
         wait_cyc(H);
      end
      ps2_clk = 1'b0;
      wait_cyc(H);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic par, input logic glitch);
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i], glitch);
      send_bit(par, glitch);
      send_bit(1'b1, 1'b0);
      ps2_data = 1'b1;
      wait_cyc(2 * H);
   endtask

   initial begin
      int v0, e0;
      logic [7:0] tmp;
      wait_cyc(4);
      check("reset_data", key_data_out, 8'h00);
      check("reset_pressed", key_pressed, 0);
      check("reset_ext", key_extended, 0);
      check("reset_valid", key_valid, 0);
      check("reset_err", frame_err, 0);
      reset = 1'b0;
      wait_cyc(20);

      // 1: make 1C
      send_frame(8'h1C, 1'b0, 1'b0);
      check("t1_vcount", vcount, 1);
      check("t1_data", key_data_out, 8'h1C);
      check("t1_pressed", key_pressed, 1);
      check("t1_ext", key_extended, 0);
      check("t1_ecount", ecount, 0);

      // 2: break 1C
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("t2_pressed", key_pressed, 0);
      check("t2_vcount", vcount, 1);
      check("t2_data", key_data_out, 8'h1C);

      // 3: bad parity then good 32
      send_frame(8'h32, 1'b1, 1'b0);
      check("t3_ecount", ecount, 1);
      check("t3_data_kept", key_data_out, 8'h1C);
      check("t3_vcount", vcount, 1);
      send_frame(8'h32, 1'b0, 1'b0);
      check("t3_data", key_data_out, 8'h32);
      check("t3_vcount2", vcount, 2);

      // 4: extended make and break of 75
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check("t4_data", key_data_out, 8'h75);
      check("t4_ext", key_extended, 1);
      check("t4_pressed", key_pressed, 1);
      send_frame(8'hE0, 1'b0, 1'b0);
      send_frame(8'hF0, 1'b1, 1'b0);
      send_frame(8'h75, 1'b0, 1'b0);
      check("t4_release", key_pressed, 0);
      check("t4_vcount", vcount, 3);

      // 5: glitches ignored, then timeout of partial frame
      send_frame(8'h16, 1'b0, 1'b1);
      check("t5_glitch_data", key_data_out, 8'h16);
      check("t5_glitch_vcount", vcount, 4);
      check("t5_glitch_ecount", ecount, 1);
      v0 = vcount;
      e0 = ecount;
      tmp = 8'h2B;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(tmp[i], 1'b0);
      ps2_data = 1'b1;
      wait_cyc(30000);
      check("t5_to_vcount", vcount, v0);
      check("t5_to_ecount", ecount, e0);
      send_frame(8'h16, 1'b0, 1'b0);
      check("t5_after_vcount", vcount, v0 + 1);
      check("t5_after_data", key_data_out, 8'h16);
      check("t5_after_ecount", ecount, e0);

      // 6: reset mid-frame, then 45
      tmp = 8'h1C;
      send_bit(1'b0, 1'b0);
      for (int i = 0; i < 4; i++) send_bit(tmp[i], 1'b0);
      reset = 1'b1;
      #1;
      check("t6_rst_data", key_data_out, 8'h00);
      check("t6_rst_pressed", key_pressed, 0);
      check("t6_rst_ext", key_extended, 0);
      wait_cyc(3);
      reset = 1'b0;
      ps2_data = 1'b1;
      wait_cyc(20);
      v0 = vcount;
      send_frame(8'h45, 1'b0, 1'b0);
      check("t6_data", key_data_out, 8'h45);
      check("t6_pressed", key_pressed, 1);
      check("t6_ext", key_extended, 0);
      check("t6_vcount", vcount, v0 + 1);

      check("pulse_width", pulse_bad, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
